// File: rtl/valve_ctrl_pkg.sv
// Shared parameter defaults and state encoding for the valve shift-register driver.
// The state encoding is fixed so bench checkers and debug tooling can decode it.
package valve_ctrl_pkg;

   localparam int NUM_VALVES_DEF   = 32;
   localparam int CLK_DIV_DEF      = 4;
   localparam int LATCH_CYCLES_DEF = 2;

   // Wide enough for the largest legal latch hold of 15 cycles
   localparam int LATCH_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LATCH    = 2'd3
   } valve_state_t;

endpackage

// File: rtl/shift_tick_gen.sv
// Half-period timer for the serial clock: while enabled, emits a one-cycle tick
// every CLK_DIV cycles, counting from the cycle enable first rises.
module shift_tick_gen
   import valve_ctrl_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   // Held at zero while disabled so every phase starts a full half-period
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!en || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/valve_shift_driver.sv
// Serialises a valve open/close word MSB first onto sclk/sdo, then pulses le so the
// downstream chain latches it; done marks the return to IDLE.
module valve_shift_driver
   import valve_ctrl_pkg::*;
#(
   parameter int NUM_VALVES   = NUM_VALVES_DEF,
   parameter int CLK_DIV      = CLK_DIV_DEF,
   parameter int LATCH_CYCLES = LATCH_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_VALVES-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  sclk,
   output logic                  sdo,
   output logic                  le,
   output logic                  done,
   output valve_state_t          state
);

   // Handshake: a frame transfers on the rising edge where in_valid && in_ready.
   // in_ready is high only in IDLE; in_valid seen in any other state is dropped.

   localparam int BIT_W = $clog2(NUM_VALVES);
   localparam logic [BIT_W-1:0]       LAST_BIT   = BIT_W'(NUM_VALVES - 1);
   localparam logic [LATCH_CNT_W-1:0] LAST_LATCH = LATCH_CNT_W'(LATCH_CYCLES - 1);

   valve_state_t           state_q, state_d;
   logic [NUM_VALVES-1:0]  shift_q, shift_d;
   logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [LATCH_CNT_W-1:0] latch_cnt_q, latch_cnt_d;
   logic                   tick, tick_en;
   logic                   sdo_d, done_d;

   assign tick_en = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);

   shift_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .tick (tick)
   );

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      latch_cnt_d = latch_cnt_q;
      done_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               shift_d   = in_data;
               bit_cnt_d = '0;
               state_d   = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (tick) begin
               state_d = SHIFT_HI;
            end
         end
         SHIFT_HI: begin
            if (tick) begin
               shift_d = shift_q << 1;
               // Last bit clears the counter instead of wrapping it
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = LATCH;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  state_d   = SHIFT_LO;
               end
            end
         end
         LATCH: begin
            if (latch_cnt_q == LAST_LATCH) begin
               latch_cnt_d = '0;
               state_d     = IDLE;
               done_d      = 1'b1;
            end else begin
               latch_cnt_d = latch_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered from next-state values so they line up with state_q
   assign sdo_d = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? shift_d[NUM_VALVES-1] : 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         latch_cnt_q <= '0;
         in_ready    <= 1'b0;
         sclk        <= 1'b0;
         sdo         <= 1'b0;
         le          <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         latch_cnt_q <= latch_cnt_d;
         in_ready    <= (state_d == IDLE);
         sclk        <= (state_d == SHIFT_HI);
         sdo         <= sdo_d;
         le          <= (state_d == LATCH);
         done        <= done_d;
      end
   end

   assign state = state_q;

endmodule

// File: doc/valve_shift_driver.md
VALVE_SHIFT_DRIVER -- requirements
Module: valve_shift_driver

Interface
REQ-001 Parameter NUM_VALVES, default 32: number of valve bits per frame; legal range 2..64.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per serial-clock half-period; legal range 1..255.
REQ-003 Parameter LATCH_CYCLES, default 2: clk cycles the latch-enable pulse is held; legal range 1..15.
REQ-004 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  NUM_VALVES  valve open/close word; bit NUM_VALVES-1 addresses the farthest valve.
REQ-007 in_valid  input  1  in_data is offered.
REQ-008 in_ready  output  1  block can accept a frame.
REQ-009 sclk  output  1  serial shift clock to the valve shift-register chain.
REQ-010 sdo  output  1  serial data, MSB first.
REQ-011 le  output  1  latch enable; the downstream latch stage captures its data while le is high.
REQ-012 done  output  1  one-cycle pulse when a frame is latched.

Function
REQ-013 The block SHALL have the states IDLE, SHIFT_LO, SHIFT_HI and LATCH.
REQ-014 IDLE: in_ready=1, sclk=0, le=0; a frame SHALL be accepted on the rising edge where in_valid&&in_ready, capturing in_data into the shift register, setting bit_cnt=0 and moving to SHIFT_LO.
REQ-015 in_ready SHALL be 0 in every state except IDLE; in_valid asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-016 SHIFT_LO: sclk=0 and sdo=shift_reg[MSB] for exactly CLK_DIV cycles, then SHIFT_HI.
REQ-017 SHIFT_HI: sclk=1 with sdo held for exactly CLK_DIV cycles; on exit the shift register SHALL shift left by one and bit_cnt SHALL increment.
REQ-018 Exit from SHIFT_HI SHALL go to SHIFT_LO while bit_cnt < NUM_VALVES-1, otherwise to LATCH.
REQ-019 LATCH: sclk=0, sdo=0, le=1 for exactly LATCH_CYCLES cycles, then IDLE.
REQ-020 done SHALL pulse high for the single cycle in which the block re-enters IDLE after LATCH.
REQ-021 Accept-to-done latency SHALL be exactly 2*CLK_DIV*NUM_VALVES + LATCH_CYCLES + 1 cycles (default 259).
REQ-022 A frame accepted in the cycle immediately after done SHALL be legal; back-to-back frames SHALL therefore be separated by at least one IDLE cycle.
REQ-023 sclk, sdo and le SHALL be driven directly from registers (glitch-free), and le SHALL NOT overlap an sclk high phase.
REQ-024 The half-period counter SHALL be ceil(log2(CLK_DIV+1)) bits wide; bit_cnt SHALL be ceil(log2(NUM_VALVES)) bits wide with no wrap inside a frame.

Reset
REQ-025 While rst=0, the block SHALL set state=IDLE, sclk=0, sdo=0, le=0, done=0, the shift register to 0 and all counters to 0.
REQ-026 in_ready SHALL read 0 while rst=0 and 1 from the first clock edge after release.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame, and le SHALL NOT pulse for that frame.

Structure
REQ-028 Parameter defaults and the state encoding (2-bit: IDLE=0, SHIFT_LO=1, SHIFT_HI=2, LATCH=3) SHALL live in the shared package valve_ctrl_pkg.
REQ-029 The half-period counter SHALL be a sub-module, shift_tick_gen, emitting a one-cycle tick every CLK_DIV cycles while enabled; all other logic SHALL be in valve_shift_driver.

Verification
REQ-030 Send in_data=32'hA5A5_0F0F with defaults -> the sampled sdo sequence on sclk rising edges is 1010_0101_1010_0101_0000_1111_0000_1111, then le is high for 2 cycles, then done pulses 259 cycles after accept.
REQ-031 Hold in_valid high with 32'hFFFF_FFFF and then 32'h0000_0001 offered during the busy period -> only the first frame is shifted, the second is accepted on the cycle after done, and exactly 2 le pulses occur.
REQ-032 Assert rst for 3 cycles after bit 10 of a frame -> outputs are zero immediately (asynchronously), no le pulse occurs, and a fresh frame 32'h1234_5678 then shifts correctly.
REQ-033 Set CLK_DIV=1, NUM_VALVES=2, LATCH_CYCLES=1 with in_data=2'b10 -> sclk period is 2 cycles, sdo bits are 1 then 0, and done arrives 6 cycles after accept.
REQ-034 Across 200 random frames with random in_valid gaps -> le is never high while sclk=1, the sdo stream matches a reference model, and in_ready=1 only in IDLE.
